// File: rtl/div_mod_defs.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : div_mod_defs (package)                                           |
// | Purpose  : Shared definitions for the div/mod datapath and its consumers:   |
// |            operand widths, counter width and FSM state encodings.           |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
package div_mod_defs;

  localparam int WIDTH_DEF     = 16;
  localparam int OUT_WIDTH_DEF = 2 * WIDTH_DEF;
  localparam int CNT_WIDTH_DEF = $clog2(WIDTH_DEF);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MULT    = 2'd1,
    ST_ADD_REM = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Counter width for a given operand width; never below one bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage : div_mod_defs
`default_nettype wire

// File: rtl/mult_shift_add_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : mult_shift_add_unit                                              |
// | Purpose  : Sequential shift-add multiplier datapath. One partial product    |
// |            per step; the accumulator can also be overwritten by the parent  |
// |            (used to fold in the remainder).                                 |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module mult_shift_add_unit
  import div_mod_defs::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic                 acc_wr,
  input  logic [WIDTH-1:0]     multiplicand_in,
  input  logic [WIDTH-1:0]     multiplier_in,
  input  logic [OUT_WIDTH-1:0] acc_in,
  output logic [OUT_WIDTH-1:0] acc,
  output logic                 last_step
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic [OUT_WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic [CNT_W-1:0]     cnt;

  // The step that runs while cnt holds WIDTH-1 is the final partial product.
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  // Operand capture, one partial product per step, or accumulator overwrite.
  always_ff @(posedge clk) begin
    if (!reset) begin
      multiplicand <= '0;
      multiplier   <= '0;
      acc          <= '0;
      cnt          <= '0;
    end else if (load) begin
      multiplicand <= {{(OUT_WIDTH - WIDTH){1'b0}}, multiplicand_in};
      multiplier   <= multiplier_in;
      acc          <= '0;
      cnt          <= '0;
    end else if (step) begin
      if (multiplier[0]) begin
        acc <= acc + multiplicand;
      end
      multiplicand <= multiplicand << 1;
      multiplier   <= multiplier >> 1;
      cnt          <= cnt + CNT_W'(1);
    end else if (acc_wr) begin
      acc <= acc_in;
    end
  end

endmodule : mult_shift_add_unit
`default_nettype wire

// File: rtl/div_mod_reconstruct.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : div_mod_reconstruct                                              |
// | Purpose  : Rebuilds dividend = quotient*divisor + remainder and flags       |
// |            operand sets no legal division could produce (divisor==0 or      |
// |            remainder >= divisor).                                           |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module div_mod_reconstruct
  import div_mod_defs::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int OUT_WIDTH = 2 * WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     quotient,
  input  logic [WIDTH-1:0]     divisor,
  input  logic [WIDTH-1:0]     remainder,
  input  logic                 valid_input,
  output logic                 busy,
  output logic                 valid_output,
  output logic [OUT_WIDTH-1:0] final_output,
  output logic                 div_zero,
  output logic                 rem_error
);

  state_t state, state_next;

  logic                 load, step, acc_wr, last_step;
  logic [OUT_WIDTH-1:0] acc, acc_sum;
  logic [WIDTH-1:0]     divisor_q, remainder_q;
  logic                 div_zero_pend, rem_error_pend;

  mult_shift_add_unit #(
    .WIDTH     (WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_mult (
    .clk             (clk),
    .reset           (reset),
    .load            (load),
    .step            (step),
    .acc_wr          (acc_wr),
    .multiplicand_in (quotient),
    .multiplier_in   (divisor),
    .acc_in          (acc_sum),
    .acc             (acc),
    .last_step       (last_step)
  );

  // Product never exceeds 2^OUT_WIDTH - 2^WIDTH, so the remainder add cannot carry out.
  assign acc_sum = acc + {{(OUT_WIDTH - WIDTH){1'b0}}, remainder_q};
  assign busy    = (state != ST_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    acc_wr     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (valid_input) begin
          load       = 1'b1;
          state_next = ST_MULT;
        end
      end
      ST_MULT: begin
        step = 1'b1;
        if (last_step) begin
          state_next = ST_ADD_REM;
        end
      end
      ST_ADD_REM: begin
        acc_wr     = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Capture the divisor/remainder alongside the multiplier operands and evaluate
  // the legality flags once the multiply has finished.
  always_ff @(posedge clk) begin
    if (!reset) begin
      divisor_q      <= '0;
      remainder_q    <= '0;
      div_zero_pend  <= 1'b0;
      rem_error_pend <= 1'b0;
    end else begin
      if (load) begin
        divisor_q   <= divisor;
        remainder_q <= remainder;
      end
      if (acc_wr) begin
        div_zero_pend  <= (divisor_q == '0);
        rem_error_pend <= (remainder_q >= divisor_q);
      end
    end
  end

  // Result and flags update only on leaving DONE; valid_output is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_output <= 1'b0;
      final_output <= '0;
      div_zero     <= 1'b0;
      rem_error    <= 1'b0;
    end else begin
      valid_output <= 1'b0;
      if (state == ST_DONE) begin
        valid_output <= 1'b1;
        final_output <= acc;
        div_zero     <= div_zero_pend;
        rem_error    <= rem_error_pend;
      end
    end
  end

endmodule : div_mod_reconstruct
`default_nettype wire

// File: tb/tb_div_mod_reconstruct.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_div_mod_reconstruct                                           |
// | Purpose  : Directed self-checking bench for div_mod_reconstruct.            |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module tb_div_mod_reconstruct;

  localparam int WIDTH     = 16;
  localparam int OUT_WIDTH = 32;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [WIDTH-1:0]     quotient = '0;
  logic [WIDTH-1:0]     divisor = '0;
  logic [WIDTH-1:0]     remainder = '0;
  logic                 valid_input = 1'b0;
  logic                 busy;
  logic                 valid_output;
  logic [OUT_WIDTH-1:0] final_output;
  logic                 div_zero;
  logic                 rem_error;

  int checks = 0;
  int passes = 0;

  div_mod_reconstruct #(
    .WIDTH     (WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .quotient     (quotient),
    .divisor      (divisor),
    .remainder    (remainder),
    .valid_input  (valid_input),
    .busy         (busy),
    .valid_output (valid_output),
    .final_output (final_output),
    .div_zero     (div_zero),
    .rem_error    (rem_error)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Starts an operation just after a clock edge; the next edge is edge 0.
  // Optionally pulses valid_input with Q=1,D=1 at edge pulse_edge (0 = no pulse).
  // Returns the edge index after which valid_output was first seen (0 on timeout).
  task automatic run_op(input logic [15:0] q, input logic [15:0] d, input logic [15:0] r,
                        input int pulse_edge, output int edges);
    quotient    = q;
    divisor     = d;
    remainder   = r;
    valid_input = 1'b1;
    @(posedge clk); #1;
    valid_input = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    edges = 0;
    for (int i = 1; i <= 40; i++) begin
      if (pulse_edge != 0 && i == pulse_edge) begin
        quotient    = 16'd1;
        divisor     = 16'd1;
        remainder   = 16'd0;
        valid_input = 1'b1;
      end
      @(posedge clk); #1;
      valid_input = 1'b0;
      if (valid_output) begin
        edges = i;
        break;
      end
    end
    if (edges == 0) check("valid_timeout", 32'd0, 32'd1);
  endtask

  int e;
  int seen;

  initial begin
    // Reset held with random stimulus, valid_input asserted.
    for (int i = 0; i < 3; i++) begin
      quotient    = 16'($urandom);
      divisor     = 16'($urandom);
      remainder   = 16'($urandom);
      valid_input = 1'b1;
      @(posedge clk); #1;
    end
    check("rst_busy",  {31'd0, busy},         32'd0);
    check("rst_valid", {31'd0, valid_output}, 32'd0);
    check("rst_final", final_output,          32'd0);
    check("rst_dz",    {31'd0, div_zero},     32'd0);
    check("rst_re",    {31'd0, rem_error},    32'd0);
    valid_input = 1'b0;
    reset       = 1'b1;
    @(posedge clk); #1;

    // Basic reconstruction plus latency.
    run_op(16'h1234, 16'h0010, 16'h0005, 0, e);
    check("t2_latency", e, 18);
    check("t2_final",   final_output, 32'h0001_2345);
    check("t2_dz",      {31'd0, div_zero},  32'd0);
    check("t2_re",      {31'd0, rem_error}, 32'd0);
    @(posedge clk); #1;
    check("t2_pulse_end", {31'd0, valid_output}, 32'd0);
    check("t2_idle",      {31'd0, busy},         32'd0);

    // Largest operands.
    run_op(16'hFFFF, 16'hFFFF, 16'hFFFE, 0, e);
    check("t3_final", final_output, 32'hFFFE_FFFF);
    check("t3_dz",    {31'd0, div_zero},  32'd0);
    check("t3_re",    {31'd0, rem_error}, 32'd0);

    // Divide-by-zero, accepted back-to-back on the earliest legal edge.
    run_op(16'h0003, 16'h0000, 16'h0007, 0, e);
    check("t4a_latency", e, 18);
    check("t4a_final", final_output, 32'h0000_0007);
    check("t4a_dz",    {31'd0, div_zero},  32'd1);
    check("t4a_re",    {31'd0, rem_error}, 32'd1);

    // Remainder equal to divisor.
    run_op(16'd2, 16'd5, 16'd5, 0, e);
    check("t4b_final", final_output, 32'h0000_000F);
    check("t4b_dz",    {31'd0, div_zero},  32'd0);
    check("t4b_re",    {31'd0, rem_error}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("t4b_hold_final", final_output, 32'h0000_000F);
    check("t4b_hold_re",    {31'd0, rem_error}, 32'd1);

    // valid_input while busy is ignored.
    run_op(16'h0100, 16'h0100, 16'h0000, 4, e);
    check("t5_latency", e, 18);
    check("t5_final",   final_output, 32'h0001_0000);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (valid_output) seen++;
    end
    check("t5_no_extra_valid", seen, 0);

    // Reset mid-operation discards the result.
    quotient    = 16'h00AA;
    divisor     = 16'h0033;
    remainder   = 16'h0001;
    valid_input = 1'b1;
    @(posedge clk); #1;
    valid_input = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("t6_rst_busy",  {31'd0, busy},         32'd0);
    check("t6_rst_valid", {31'd0, valid_output}, 32'd0);
    check("t6_rst_final", final_output,          32'd0);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (valid_output) seen++;
    end
    check("t6_no_valid", seen, 0);
    run_op(16'd7, 16'd6, 16'd5, 0, e);
    check("t6_final", final_output, 32'h0000_002F);
    check("t6_re",    {31'd0, rem_error}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_div_mod_reconstruct
`default_nettype wire
